sdc_rd_blk_crc_chk: RTL

- Downstream stage of the single-block SD read path. Consumes the 64-bit words and the received CRC-16 produced by the block-read collector.
- Writes each word into the data BRAM through a simple write port.
- Recomputes CRC-16-CCITT over the 512-byte block, compares it with the received CRC, and flags pass or fail to the ADMA2 and host-status logic.
- Runs entirely in the sdc_clk domain.

---
 rtl/sdc_rd_blk_crc_chk.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sdc_rd_blk_crc_chk.sv
// Single-block SD read back end: writes collected 64-bit words into BRAM and checks the
// block's CRC-16-CCITT (init 0, MSB first, two bits per clock) against the received CRC.
module sdc_rd_blk_crc_chk #(
  parameter int unsigned WORDS_PER_BLK = 64,
  parameter int unsigned AW            = 6,
  parameter logic [15:0] POLY          = 16'h1021
) (
  input  logic          sdc_clk,
  input  logic          reset,
  input  logic          latch_wrd_strb,
  input  logic [63:0]   dat_wrd,
  input  logic          latch_crc_strb,
  input  logic [15:0]   crc_16,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [63:0]   bram_dat,
  output logic [15:0]   crc_calc,
  output logic          blk_done,
  output logic          crc_ok,
  output logic          crc_err,
  output logic          ovr_err
);

  // One extra bit so the index can represent WORDS_PER_BLK itself.
  localparam int unsigned IW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWaitWrd,
    StWaitCrc,
    StCheck
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   shreg_q, shreg_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] wrd_idx_q, wrd_idx_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   crc_cap_q, crc_cap_d;
  logic          crc_rx_q, crc_rx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          load;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    wrd_idx_d = wrd_idx_q;
    crc_d     = crc_q;
    crc_cap_d = crc_cap_q;
    crc_rx_d  = crc_rx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    load      = 1'b0;

    if (latch_crc_strb) begin
      if (state_q == StIdle) begin
        ovr_d = 1'b1;
      end else begin
        crc_cap_d = crc_16;
        crc_rx_d  = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (latch_wrd_strb) begin
          crc_d     = 16'h0000;
          ok_d      = 1'b0;
          err_d     = 1'b0;
          crc_rx_d  = 1'b0;
          wrd_idx_d = '0;
          load      = 1'b1;
        end
      end
      StShift: begin
        crc_d     = crc_step(crc_step(crc_q, shreg_q[63]), shreg_q[62]);
        shreg_d   = {shreg_q[61:0], 2'b00};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          wrd_idx_d = wrd_idx_q + 1'b1;
          state_d   = (wrd_idx_d == IW'(WORDS_PER_BLK)) ? StWaitCrc : StWaitWrd;
        end
        if (latch_wrd_strb) ovr_d = 1'b1;
      end
      StWaitWrd: begin
        if (latch_wrd_strb) load = 1'b1;
      end
      StWaitCrc: begin
        if (latch_wrd_strb) ovr_d = 1'b1;
        if (crc_rx_q) state_d = StCheck;
      end
      StCheck: begin
        done_d  = 1'b1;
        ok_d    = (crc_q == crc_cap_q);
        err_d   = (crc_q != crc_cap_q);
        state_d = StIdle;
        if (latch_wrd_strb) ovr_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shreg_d   = dat_wrd;
      bit_cnt_d = 5'd0;
      we_d      = 1'b1;
      addr_d    = wrd_idx_d[AW-1:0];
      dat_d     = dat_wrd;
      state_d   = StShift;
    end
  end

  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      wrd_idx_q <= '0;
      crc_q     <= '0;
      crc_cap_q <= '0;
      crc_rx_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      wrd_idx_q <= wrd_idx_d;
      crc_q     <= crc_d;
      crc_cap_q <= crc_cap_d;
      crc_rx_q  <= crc_rx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_dat  = dat_q;
  assign crc_calc  = crc_q;
  assign blk_done  = done_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign ovr_err   = ovr_q;

endmodule
